// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic pipeline stage register for any stage boundary
// (IF/ID, ID/EX, EX/MEM, MEM/WB).
//
// - Carries NFIELD fields of DATA_W bits each. Field k sits at
//   bits [k*DATA_W +: DATA_W].
// - Valid/ready handshake on both sides.
// - A 2-entry skid buffer keeps in_ready free of any combinational path
//   from out_ready.
// - EN=0 freezes all state and blocks transfers on both sides.
// - CLR flushes both slots to bubbles holding NOP_VAL. CLR has priority over EN.
//
// Optional build macro: PIPE_STAGE_PERF_CNT_EN
// - Adds saturating 16-bit stall_cnt and bubble_cnt outputs.
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int NFIELD = 2,
  parameter logic [NFIELD*DATA_W-1:0] NOP_VAL = '0
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic                     EN,
  input  logic                     CLR,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NFIELD*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NFIELD*DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  output logic [15:0]              stall_cnt,
  output logic [15:0]              bubble_cnt
`endif
);

  localparam int W = NFIELD * DATA_W;

  // Main slot feeds the output.
  // The skid slot catches the one payload accepted while the main slot
  // could not drain.
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         s_valid;
  logic [W-1:0] s_data;

  logic         m_valid_next;
  logic [W-1:0] m_data_next;
  logic         s_valid_next;
  logic [W-1:0] s_data_next;

  logic in_fire;
  logic out_fire;

  // Handshake outputs.
  // - in_ready depends only on registered state and EN.
  // - Once the skid slot is occupied, no further input is accepted.
  assign in_ready  = EN & ~s_valid;
  assign out_valid = EN & m_valid;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // When the stage is empty, each field shows its NOP_VAL slice.
  genvar gi;
  generate
    for (gi = 0; gi < NFIELD; gi++) begin : g_field
      assign out_data[gi*DATA_W +: DATA_W] = m_valid ? m_data[gi*DATA_W +: DATA_W]
                                                     : NOP_VAL[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Next-state for both slots.
  // Priority: flush, then stall (hold), then normal handshake update.
  always_comb begin
    m_valid_next = m_valid;
    m_data_next  = m_data;
    s_valid_next = s_valid;
    s_data_next  = s_data;
    if (CLR) begin
      // Any input offered this cycle is discarded.
      // An output taken this cycle has already completed downstream.
      m_valid_next = 1'b0;
      m_data_next  = NOP_VAL;
      s_valid_next = 1'b0;
      s_data_next  = NOP_VAL;
    end else if (EN) begin
      if (!m_valid) begin
        // Empty stage: the incoming payload goes straight to the main slot.
        if (in_fire) begin
          m_valid_next = 1'b1;
          m_data_next  = in_data;
        end
      end else if (out_fire) begin
        if (s_valid) begin
          // Drain the skid slot into main.
          // in_ready was low, so no input arrives this cycle.
          m_data_next  = s_data;
          s_valid_next = 1'b0;
        end else if (in_fire) begin
          // Pass-through at full throughput.
          m_data_next = in_data;
        end else begin
          m_valid_next = 1'b0;
        end
      end else if (in_fire) begin
        // Main slot is blocked downstream, so park the new payload in skid.
        s_valid_next = 1'b1;
        s_data_next  = in_data;
      end
    end
  end

  // Slot registers.
  // Asynchronous reset empties the stage immediately.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      m_valid <= 1'b0;
      m_data  <= NOP_VAL;
      s_valid <= 1'b0;
      s_data  <= NOP_VAL;
    end else begin
      m_valid <= m_valid_next;
      m_data  <= m_data_next;
      s_valid <= s_valid_next;
      s_data  <= s_data_next;
    end
  end

`ifdef PIPE_STAGE_PERF_CNT_EN
  // Stall counter: cycles with EN low. Saturates; cleared by reset or flush.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      stall_cnt <= 16'h0000;
    end else if (CLR) begin
      stall_cnt <= 16'h0000;
    end else if (!EN && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  // Bubble counter: enabled cycles with an empty main slot.
  // Saturates; cleared by reset or flush.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      bubble_cnt <= 16'h0000;
    end else if (CLR) begin
      bubble_cnt <= 16'h0000;
    end else if (EN && !m_valid && (bubble_cnt != 16'hFFFF)) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid.
// - Directed vector table.
// - Hand-written asynchronous reset sequence.
// - Randomized traffic checked against a 2-deep queue model.
// - Perf counter checks when PIPE_STAGE_PERF_CNT_EN is defined.
module tb_pipe_stage_skid;

  localparam int DATA_W = 32;
  localparam int NFIELD = 2;
  localparam int W = DATA_W * NFIELD;
  localparam logic [W-1:0] NOP = '0;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic         clk = 1'b0;
  logic         RST;
  logic         EN;
  logic         CLR;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [15:0]  stall_cnt;
  logic [15:0]  bubble_cnt;
`endif

  pipe_stage_skid #(.DATA_W(DATA_W), .NFIELD(NFIELD), .NOP_VAL(NOP)) dut (
    .clk       (clk),
    .RST       (RST),
    .EN        (EN),
    .CLR       (CLR),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the stage is a FIFO of capacity 2.
  logic [W-1:0] mq[$];

  typedef struct {
    logic         en;
    logic         clr;
    logic         iv;
    logic         ord;
    logic [W-1:0] din;
    logic         eir;
    logic         eov;
    logic [W-1:0] eod;
  } vec_t;
  vec_t vq[$];

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic checkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic clr, input logic iv, input logic ord,
                       input logic [W-1:0] d);
    EN        = en;
    CLR       = clr;
    in_valid  = iv;
    out_ready = ord;
    in_data   = d;
  endtask

  // Advance one clock and apply the FIFO rules to the model.
  task automatic tick();
    bit inf;
    bit outf;
    inf  = in_valid && EN && (mq.size() < 2);
    outf = EN && (mq.size() > 0) && out_ready;
    @(posedge clk);
    if (CLR) begin
      mq.delete();
    end else if (EN) begin
      if (outf) void'(mq.pop_front());
      if (inf) mq.push_back(in_data);
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [W-1:0] od;
    od = (mq.size() > 0) ? mq[0] : NOP;
    check1({tag, " in_ready"}, in_ready, EN && (mq.size() < 2));
    check1({tag, " out_valid"}, out_valid, EN && (mq.size() > 0));
    checkw({tag, " out_data"}, out_data, od);
  endtask

  task automatic add(input logic en, input logic clr, input logic iv, input logic ord,
                     input logic [W-1:0] din, input logic eir, input logic eov,
                     input logic [W-1:0] eod);
    vec_t v;
    v.en  = en;
    v.clr = clr;
    v.iv  = iv;
    v.ord = ord;
    v.din = din;
    v.eir = eir;
    v.eov = eov;
    v.eod = eod;
    vq.push_back(v);
  endtask

  localparam logic [W-1:0] P0 = {32'h00000013, 32'h00000000};
  localparam logic [W-1:0] P1 = {32'h00100093, 32'h00000004};
  localparam logic [W-1:0] P2 = {32'h00200113, 32'h00000008};
  localparam logic [W-1:0] P3 = {32'h00300193, 32'h0000000C};
  localparam logic [W-1:0] PA = 64'hAAAA_0001_0000_0010;
  localparam logic [W-1:0] PB = 64'hBBBB_0002_0000_0014;
  localparam logic [W-1:0] PC = 64'hCCCC_0003_0000_0018;
  localparam logic [W-1:0] PD = 64'hDDDD_0004_0000_001C;
  localparam logic [W-1:0] PE = 64'hEEEE_0005_0000_0020;
  localparam logic [W-1:0] PF = 64'hFFFF_0006_0000_0024;
  localparam logic [W-1:0] PG = 64'h1234_0007_0000_0028;

  initial begin
    // Directed vector table.
    // Fields: en, clr, in_valid, out_ready, in_data, exp in_ready, exp out_valid, exp out_data.

    // Streaming: each payload appears one cycle after entry, with no gaps.
    add(H, L, H, H, P0, H, L, NOP);
    add(H, L, H, H, P1, H, H, P0);
    add(H, L, H, H, P2, H, H, P1);
    add(H, L, H, H, P3, H, H, P2);
    add(H, L, L, H, NOP, H, H, P3);
    add(H, L, L, H, NOP, H, L, NOP);

    // Back-pressure: A goes to main, B to skid, and C is held upstream.
    add(H, L, H, L, PA, H, L, NOP);
    add(H, L, H, L, PB, H, H, PA);
    add(H, L, H, L, PC, L, H, PA);

    // Stall for 3 cycles with both slots full: no transfers, contents kept.
    add(L, L, H, H, PC, L, L, PA);
    add(L, L, H, H, PC, L, L, PA);
    add(L, L, H, H, PC, L, L, PA);

    // Resume: A, B, C drain in order.
    add(H, L, H, H, PC, L, H, PA);
    add(H, L, H, H, PC, H, H, PB);
    add(H, L, L, H, NOP, H, H, PC);

    // Flush with both slots full and input offered.
    add(H, L, H, L, PD, H, L, NOP);
    add(H, L, H, L, PE, H, H, PD);
    add(H, H, H, L, PF, L, H, PD);
    add(H, L, L, H, NOP, H, L, NOP);

    // Flush discards an accepted input in the same cycle.
    add(H, H, H, H, PG, H, L, NOP);
    add(H, L, L, H, NOP, H, L, NOP);

    // Reset state while RST is held.
    RST = 1'b1;
    drive(H, L, L, L, NOP);
    mq.delete();
    #2;
    check1("reset in_ready", in_ready, 1'b1);
    check1("reset out_valid", out_valid, 1'b0);
    checkw("reset out_data", out_data, NOP);
    repeat (2) @(posedge clk);
    #3;
    RST = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].en, vq[i].clr, vq[i].iv, vq[i].ord, vq[i].din);
      #3;
      check1($sformatf("vec%0d in_ready", i), in_ready, vq[i].eir);
      check1($sformatf("vec%0d out_valid", i), out_valid, vq[i].eov);
      checkw($sformatf("vec%0d out_data", i), out_data, vq[i].eod);
      tick();
    end

    // Mid-cycle asynchronous reset: outputs clear without waiting for an edge.
    drive(H, L, H, L, PA);
    tick();
    drive(H, L, L, L, NOP);
    #1;
    check1("pre-reset out_valid", out_valid, 1'b1);
    checkw("pre-reset out_data", out_data, PA);
    RST = 1'b1;
    mq.delete();
    #1;
    check1("async reset out_valid", out_valid, 1'b0);
    checkw("async reset out_data", out_data, NOP);
    #1;
    RST = 1'b0;
    #1;
    check1("post-reset in_ready", in_ready, 1'b1);
    tick();

    // Randomized traffic checked against the model.
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 7) != 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0,
            {$urandom, $urandom});
      #3;
      check_model($sformatf("rand%0d", c));
      tick();
    end

`ifdef PIPE_STAGE_PERF_CNT_EN
    // Perf counters: flush clears them, then count stall and bubble cycles.
    drive(H, H, L, L, NOP);
    tick();
    checkw("perf cleared stall", {48'b0, stall_cnt}, 64'd0);
    checkw("perf cleared bubble", {48'b0, bubble_cnt}, 64'd0);
    drive(L, L, L, L, NOP);
    repeat (5) tick();
    drive(H, L, L, L, NOP);
    repeat (3) tick();
    checkw("perf stall_cnt", {48'b0, stall_cnt}, 64'd5);
    checkw("perf bubble_cnt", {48'b0, bubble_cnt}, 64'd3);
    drive(L, L, L, L, NOP);
    repeat (70000) @(posedge clk);
    #1;
    checkw("perf stall saturate", {48'b0, stall_cnt}, 64'h0000_0000_0000_FFFF);
    checkw("perf bubble held", {48'b0, bubble_cnt}, 64'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
